hazard_controller: RTL and testbench



---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_if.sv | 22 ++
 rtl/hazard_fields.sv | 61 ++++++
 rtl/hazard_controller.sv | 111 +++++++++++
 tb/tb_hazard_controller.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared opcode/ALU constants, architectural register numbers and the
// in-flight writer slot type for the pipeline hazard controller.
package hazard_pkg;

    // Opcodes (instr[31:27])
    localparam logic [4:0] RTYPE = 5'b00000;
    localparam logic [4:0] J     = 5'b00001;
    localparam logic [4:0] BNE   = 5'b00010;
    localparam logic [4:0] JAL   = 5'b00011;
    localparam logic [4:0] JR    = 5'b00100;
    localparam logic [4:0] ADDI  = 5'b00101;
    localparam logic [4:0] BLT   = 5'b00110;
    localparam logic [4:0] SW    = 5'b00111;
    localparam logic [4:0] LW    = 5'b01000;
    localparam logic [4:0] SETX  = 5'b10101;
    localparam logic [4:0] BEX   = 5'b10110;

    // R-type ALU ops (instr[6:2]) that run on the multi-cycle unit
    localparam logic [4:0] MUL = 5'b00110;
    localparam logic [4:0] DIV = 5'b00111;

    localparam logic [4:0] REG_RA     = 5'd31;
    localparam logic [4:0] REG_STATUS = 5'd30;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } slot_t;

    // RAW check of one in-flight writer against the decode sources.
    // A zero destination never hits, so r0 sources can never match either.
    function automatic logic raw_match(slot_t s, logic [4:0] src1, logic [4:0] src2,
                                       logic src2_used);
        return s.valid && (s.dest != 5'd0) &&
               ((s.dest == src1) || (src2_used && (s.dest == src2)));
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode-side handshake between the pipeline (master) and the hazard
// controller (slave).
interface hazard_if;
    logic [31:0] dec_instruction;
    logic        dec_valid;
    logic        flush_req;
    logic        stall_fd;
    logic        bubble_dx;
    logic        flush;
    logic        md_start;
    logic        md_busy;

    modport master (
        output dec_instruction, dec_valid, flush_req,
        input  stall_fd, bubble_dx, flush, md_start, md_busy
    );

    modport slave (
        input  dec_instruction, dec_valid, flush_req,
        output stall_fd, bubble_dx, flush, md_start, md_busy
    );
endinterface

// File: rtl/hazard_fields.sv
// Combinational decode of the register fields that matter for interlocks:
// sources, destination, load and mul/div classification.
module hazard_fields
    import hazard_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  src1_o,
    output logic [4:0]  src2_o,
    output logic        src2_used_o,
    output logic [4:0]  dest_o,
    output logic        dest_valid_o,
    output logic        is_load_o,
    output logic        is_md_o
);
    logic [4:0] opcode;
    logic [4:0] rd;
    logic [4:0] rt;
    logic [4:0] alu_op;
    logic       writes;
    logic       unused_bits;

    assign opcode      = instr_i[31:27];
    assign rd          = instr_i[26:22];
    assign rt          = instr_i[16:12];
    assign alu_op      = instr_i[6:2];
    assign unused_bits = ^{instr_i[11:7], instr_i[1:0]};

    // Source/destination selection by opcode
    always_comb begin
        src1_o      = instr_i[21:17];
        // Every format carries a second register field that is compared.
        src2_used_o = 1'b1;
        src2_o      = rt;
        dest_o      = rd;
        writes      = 1'b0;
        is_load_o   = 1'b0;
        if (opcode == BNE || opcode == JR || opcode == ADDI ||
            opcode == BLT || opcode == SW) begin
            src2_o = rd;
        end
        case (opcode)
            RTYPE, ADDI: writes = 1'b1;
            LW: begin
                writes    = 1'b1;
                is_load_o = 1'b1;
            end
            JAL: begin
                writes = 1'b1;
                dest_o = REG_RA;
            end
            SETX: begin
                writes = 1'b1;
                dest_o = REG_STATUS;
            end
            default: writes = 1'b0;
        endcase
        dest_valid_o = writes && (dest_o != 5'd0);
        is_md_o      = (opcode == RTYPE) && (alu_op == MUL || alu_op == DIV);
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline interlock controller: tracks writers in X and M, runs the mul/div
// occupancy counter and drives stall/bubble/flush for F/D and D/X.
// Build option: define HAZARD_FWD_EN when the datapath forwards from M and W,
// leaving only load-use and mul/div stalls.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 8
) (
    input logic      clock,
    input logic      reset_n,
    hazard_if.slave  bus
);
    localparam logic [4:0] MdLat = 5'(MD_LATENCY);

    logic [4:0] src1, src2, dest;
    logic       src2_used, dest_valid, is_load, is_md;

    slot_t      x_q, x_d, m_q, m_d;
    logic [4:0] cnt_q, cnt_d;
    logic       md_start_q, md_start_d;
    logic       md_busy;
    logic       x_hit, raw_stall, stall, issue;

    hazard_fields u_fields (
        .instr_i      (bus.dec_instruction),
        .src1_o       (src1),
        .src2_o       (src2),
        .src2_used_o  (src2_used),
        .dest_o       (dest),
        .dest_valid_o (dest_valid),
        .is_load_o    (is_load),
        .is_md_o      (is_md)
    );

    assign md_busy = (cnt_q != 5'd0);
    assign x_hit   = bus.dec_valid && raw_match(x_q, src1, src2, src2_used);

`ifdef HAZARD_FWD_EN
    logic unused_m;
    assign unused_m  = ^m_q;
    assign raw_stall = x_hit && x_q.is_load;
`else
    logic m_hit;
    assign m_hit     = bus.dec_valid && raw_match(m_q, src1, src2, src2_used);
    assign raw_stall = x_hit || m_hit;
`endif

    assign stall = md_busy || raw_stall;
    assign issue = bus.dec_valid && !stall && !bus.flush_req;

    // Pipeline controls; flush overrides stalls, all forced low in reset
    always_comb begin
        bus.stall_fd  = 1'b0;
        bus.bubble_dx = 1'b0;
        bus.flush     = 1'b0;
        if (reset_n) begin
            if (bus.flush_req) begin
                bus.flush     = 1'b1;
                bus.bubble_dx = 1'b1;
            end else if (stall) begin
                bus.stall_fd  = 1'b1;
                bus.bubble_dx = 1'b1;
            end
        end
    end

    // Next state for the writer slots and the mul/div counter
    always_comb begin
        x_d = '0;
        m_d = '0;
        if (md_busy) begin
            // The mul/div stays in execute; nothing moves down behind it.
            x_d = x_q;
        end else begin
            m_d = x_q;
            if (issue) begin
                x_d.valid   = dest_valid;
                x_d.dest    = dest;
                x_d.is_load = is_load && dest_valid;
            end
        end
        md_start_d = issue && is_md;
        if (md_start_d) begin
            cnt_d = MdLat;
        end else if (md_busy) begin
            cnt_d = cnt_q - 5'd1;
        end else begin
            cnt_d = 5'd0;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q        <= '0;
            m_q        <= '0;
            cnt_q      <= 5'd0;
            md_start_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            md_start_q <= md_start_d;
        end
    end

    assign bus.md_start = md_start_q;
    assign bus.md_busy  = md_busy;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// instruction streams against a cycle-level reference model.
module tb_hazard_controller;
    localparam int unsigned L = 8;
`ifdef HAZARD_FWD_EN
    localparam int LuStalls  = 1;
    localparam int DepStalls = 0;
    localparam int PostFlush = 0;
`else
    localparam int LuStalls  = 2;
    localparam int DepStalls = 2;
    localparam int PostFlush = 1;
`endif

    logic clock = 1'b0;
    logic reset_n;
    hazard_if bus();

    hazard_controller #(.MD_LATENCY(L)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: destinations of the instructions in X and M (0 = none)
    int    x_dest, m_dest;
    bit    x_load;
    longint cyc;
    longint md_issue;

    function automatic logic [31:0] mk(int op, int rd, int rs, int rt, int alu);
        logic [31:0] w;
        w = '0;
        w[31:27] = 5'(op);
        w[26:22] = 5'(rd);
        w[21:17] = 5'(rs);
        w[16:12] = 5'(rt);
        w[6:2]   = 5'(alu);
        return w;
    endfunction

    function automatic int dest_of(logic [31:0] ins);
        case (int'(ins[31:27]))
            0, 5, 8: return int'(ins[26:22]);
            3:       return 31;
            21:      return 30;
            default: return 0;
        endcase
    endfunction

    function automatic bit reads(int d, logic [31:0] ins);
        int op, s2;
        op = int'(ins[31:27]);
        s2 = (op == 2 || op == 4 || op == 5 || op == 6 || op == 7) ?
             int'(ins[26:22]) : int'(ins[16:12]);
        return (d != 0) && (d == int'(ins[21:17]) || d == s2);
    endfunction

    function automatic bit is_md(logic [31:0] ins);
        return ins[31:27] == 5'd0 && (ins[6:2] == 5'd6 || ins[6:2] == 5'd7);
    endfunction

    task automatic model_reset();
        x_dest   = 0;
        m_dest   = 0;
        x_load   = 0;
        md_issue = -1000;
    endtask

    // One cycle: apply inputs, check outputs against the model, advance.
    task automatic drive(logic [31:0] ins, bit valid, bit fl, output bit st);
        bit busy, start, hx, hm, haz, e_stall, e_bubble, iss;
        bus.dec_instruction = ins;
        bus.dec_valid       = valid;
        bus.flush_req       = fl;
        #4;
        busy  = (cyc > md_issue) && (cyc <= md_issue + longint'(L));
        start = (cyc == md_issue + 1);
        hx    = valid && reads(x_dest, ins);
        hm    = valid && reads(m_dest, ins);
`ifdef HAZARD_FWD_EN
        haz = hx && x_load;
`else
        haz = hx || hm;
`endif
        e_stall  = !fl && (busy || haz);
        e_bubble = fl || busy || haz;
        check_eq("stall_fd", bus.stall_fd, e_stall);
        check_eq("bubble_dx", bus.bubble_dx, e_bubble);
        check_eq("flush", bus.flush, fl);
        check_eq("md_start", bus.md_start, start);
        check_eq("md_busy", bus.md_busy, busy);
        st  = bus.stall_fd;
        iss = valid && !e_stall && !fl;
        if (busy) begin
            m_dest = 0;
        end else begin
            m_dest = x_dest;
            x_dest = iss ? dest_of(ins) : 0;
            x_load = iss && ins[31:27] == 5'd8;
        end
        if (iss && is_md(ins)) md_issue = cyc;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        bit st;
        for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 1'b0, st);
    endtask

    // Hold an instruction in decode until it issues; count stall cycles.
    task automatic issue_ins(string tag, logic [31:0] ins, int exp_stalls);
        int stalls;
        bit st, done;
        stalls = 0;
        done   = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            drive(ins, 1'b1, 1'b0, st);
            if (st) stalls++;
            else done = 1;
        end
        check_eq({tag, "_stalls"}, stalls, exp_stalls);
    endtask

    initial begin
        int ops[12] = '{0, 0, 0, 1, 2, 3, 4, 5, 7, 8, 21, 22};
        int alus[5] = '{0, 1, 6, 7, 3};
        bit st;

        model_reset();
        cyc                 = 0;
        reset_n             = 1'b0;
        bus.dec_instruction = mk(0, 1, 1, 1, 6);
        bus.dec_valid       = 1'b1;
        bus.flush_req       = 1'b1;
        #2;
        check_eq("rst_stall", bus.stall_fd, 1'b0);
        check_eq("rst_bubble", bus.bubble_dx, 1'b0);
        check_eq("rst_flush", bus.flush, 1'b0);
        check_eq("rst_md_start", bus.md_start, 1'b0);
        check_eq("rst_md_busy", bus.md_busy, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Load-use
        idle(3);
        issue_ins("lw", mk(8, 5, 1, 0, 0), 0);
        issue_ins("lu_add", mk(0, 6, 5, 7, 0), LuStalls);

        // ALU dependency
        idle(3);
        issue_ins("add", mk(0, 5, 1, 2, 0), 0);
        issue_ins("dep_sub", mk(0, 6, 5, 3, 1), DepStalls);

        // mul occupies execute for L cycles
        idle(3);
        issue_ins("mul", mk(0, 4, 2, 3, 6), 0);
        issue_ins("after_mul", mk(0, 9, 1, 2, 0), L);

        // Flush beats load-use and kills the dependent
        idle(3);
        issue_ins("lw_fl", mk(8, 5, 1, 0, 0), 0);
        drive(mk(0, 6, 5, 7, 0), 1'b1, 1'b1, st);
        issue_ins("post_flush", mk(0, 6, 5, 7, 0), PostFlush);

        // r0 destination never interlocks
        idle(3);
        issue_ins("lw_r0", mk(8, 0, 1, 0, 0), 0);
        issue_ins("add_r0", mk(0, 2, 0, 0, 0), 0);

        // Reset in the middle of a div
        idle(3);
        issue_ins("div", mk(0, 4, 2, 3, 7), 0);
        for (int i = 0; i < 3; i++) drive(mk(0, 9, 1, 2, 0), 1'b1, 1'b0, st);
        reset_n = 1'b0;
        #1;
        check_eq("mdrst_busy", bus.md_busy, 1'b0);
        check_eq("mdrst_start", bus.md_start, 1'b0);
        check_eq("mdrst_stall", bus.stall_fd, 1'b0);
        check_eq("mdrst_bubble", bus.bubble_dx, 1'b0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc++;
        issue_ins("lw_after_rst", mk(8, 7, 1, 2, 0), 0);

        // Random streams over a small register set
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ins;
            ins = mk(ops[$urandom_range(0, 11)], $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), alus[$urandom_range(0, 4)]);
            drive(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
